multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style FSM that sequences a shared-memory, multi-cycle variant of the team's MIPS datapath. It replaces the single-cycle combinational Control unit.
- A single memory port serves both instruction fetch and data access, selected by IorD.
- The FSM drives all datapath mux selects and write strobes, waits on a memory ready handshake, and qualifies branch PC writes with the ALU Zero flag.
- It also keeps a retired-instruction counter for the bench and the debug port.

Parameters:
COUNT_WIDTH, 32, width of the RetiredCount counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
Op  in  6  instruction[31:26], taken from the instruction register
Funct  in  6  instruction[5:0]
Zero  in  1  ALU zero flag
MemReady  in  1  memory access completes this cycle
PCEn  out  1  PC register load enable
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegDst  out  1  write register select: 0 = rt, 1 = rd
MemtoReg  out  1  write data select: 0 = ALUOut, 1 = MDR
RegWrite  out  1  register file write
ZeroExt  out  1  immediate is zero-extended (ori)
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = extended immediate, 11 = sign-extended immediate shifted left 2
ALUOp  out  4  ALU operation class: 0000 ADD, 0001 SUB, 0010 OR, 0011 ADDI, 0111 RTYPE
PCSource  out  2  PC source select: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = register A
IllegalOp  out  1  sticky illegal-opcode flag
StateOut  out  4  current state, for debug
RetiredCount  out  COUNT_WIDTH  count of completed instructions

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-high.
- Outputs are decoded from the state register; PCEn and IRWrite additionally depend on the MemReady and Zero inputs.
- Any output not listed for a state is 0.

Reset:
- State goes to FETCH; RetiredCount = 0; IllegalOp = 0.
- While reset is high, PCEn, IRWrite, RegWrite, MemRead and MemWrite are forced to 0.
- Reset in the middle of an instruction abandons it; no register or memory write occurs.

State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, JR 12, TRAP 13.

State actions and transitions:
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - IRWrite = PCEn = MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (precomputes the branch target into ALUOut). Next state by opcode:
  - Op 0x23 (lw) or 0x2B (sw) -> MEM_ADDR
  - Op 0x00 with Funct 0x08 (jr) -> JR
  - Op 0x00, any other Funct -> R_EXEC
  - Op 0x04 (beq) or 0x05 (bne) -> BRANCH
  - Op 0x02 (j) -> JUMP
  - Op 0x08 (addi) or 0x0D (ori) -> I_EXEC
  - Any other Op -> see Optional Feature
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: IorD=1, MemRead=1. Waits for MemReady, then goes to MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1. Goes to FETCH.
- MEM_WRITE: IorD=1, MemWrite=1. Waits for MemReady, then goes to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=RTYPE. Goes to R_WB.
- R_WB: RegDst=1, RegWrite=1. Goes to FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10.
  - For ori: ALUOp=OR and ZeroExt=1.
  - For addi: ALUOp=ADDI.
  - Goes to I_WB.
- I_WB: RegDst=0, RegWrite=1; ZeroExt held at 1 for ori. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01. Goes to FETCH.
  - PCEn = (Op==0x04 & Zero) | (Op==0x05 & ~Zero).
- JUMP: PCSource=10, PCEn=1. Goes to FETCH.
- JR: PCSource=11, PCEn=1. Goes to FETCH.

Retired counter and debug:
- RetiredCount increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH, JUMP or JR.
- It wraps from all-ones to 0.
- MemReady held low stalls the FSM indefinitely with its strobes held steady.
- MemReady outside FETCH, MEM_READ and MEM_WRITE is ignored.
- StateOut = current state encoding.

Optional Feature:
Macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unsupported Op in DECODE goes to TRAP.
  - TRAP drives no strobes, sets IllegalOp=1 and stays in TRAP until reset.
  - RetiredCount is not incremented.
- Undefined: an unsupported Op in DECODE goes directly to FETCH as a NOP.
  - IllegalOp is tied to 0; RetiredCount is not incremented.

Test Plan:
- Reset mid-R_EXEC, then release -> StateOut=0, RegWrite never asserted, RetiredCount=0.
- add with MemReady=1 always -> state sequence 0,1,6,7,0; RegWrite=1 only in R_WB with RegDst=1; RetiredCount=1.
- lw with MemReady low for 3 cycles in MEM_READ -> MemRead and IorD held at 1 for 4 cycles; then MEM_WB asserts MemtoReg=1 and RegWrite=1.
- beq with Zero=1 and bne with Zero=1 -> PCEn=1 in BRANCH for beq, PCEn=0 for bne; PCSource=01 in both.
- Op=0x3F with the macro defined -> TRAP (StateOut=13), IllegalOp=1 held until reset.
- Op=0x3F without the macro -> back to FETCH, count unchanged.
- Preload RetiredCount near wrap with COUNT_WIDTH=4 and retire 16 instructions -> count wraps from 15 to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for the shared-memory multi-cycle MIPS datapath, with a retired-instruction counter.
// Optional feature: define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes.
`timescale 1ns/1ps
module multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             Op,
    input  logic [5:0]             Funct,
    input  logic                   Zero,
    input  logic                   MemReady,
    output logic                   PCEn,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   ZeroExt,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [3:0]             ALUOp,
    output logic [1:0]             PCSource,
    output logic                   IllegalOp,
    output logic [3:0]             StateOut,
    output logic [COUNT_WIDTH-1:0] RetiredCount
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        I_EXEC    = 4'd8,
        I_WB      = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        JR        = 4'd12,
        TRAP      = 4'd13
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0010;
    localparam logic [3:0] ALU_ADDI  = 4'b0011;
    localparam logic [3:0] ALU_RTYPE = 4'b0111;

    state_t state, nextState;
    logic   retire;
    logic   isOri;

    assign isOri    = (Op == 6'h0D);
    assign StateOut = state;

    // Memory handshake: a strobe (MemRead/MemWrite) stays asserted and the FSM holds
    // its state until MemReady is seen high in the same cycle; the access then completes.
    always_comb begin
        nextState = state;
        retire    = 1'b0;
        case (state)
            FETCH:     if (MemReady) nextState = DECODE;
            DECODE: begin
                case (Op)
                    6'h23, 6'h2B: nextState = MEM_ADDR;
                    6'h00:        nextState = (Funct == 6'h08) ? JR : R_EXEC;
                    6'h04, 6'h05: nextState = BRANCH;
                    6'h02:        nextState = JUMP;
                    6'h08, 6'h0D: nextState = I_EXEC;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    default:      nextState = TRAP;
`else
                    default:      nextState = FETCH;
`endif
                endcase
            end
            MEM_ADDR:  nextState = (Op == 6'h2B) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (MemReady) nextState = MEM_WB;
            MEM_WRITE: if (MemReady) begin
                nextState = FETCH;
                retire    = 1'b1;
            end
            R_EXEC:    nextState = R_WB;
            I_EXEC:    nextState = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP, JR: begin
                nextState = FETCH;
                retire    = 1'b1;
            end
            TRAP:      nextState = TRAP;
            default:   nextState = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FETCH;
            RetiredCount <= '0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            IllegalOp    <= 1'b0;
`endif
        end else begin
            state <= nextState;
            if (retire) RetiredCount <= RetiredCount + COUNT_WIDTH'(1);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            if (nextState == TRAP) IllegalOp <= 1'b1;
`endif
        end
    end

`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    assign IllegalOp = 1'b0;
`endif

    always_comb begin
        PCEn     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ZeroExt  = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = ALU_ADD;
        PCSource = 2'b00;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCEn    = MemReady;
            end
            DECODE:    ALUSrcB = 2'b11;
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_READ: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_RTYPE;
            end
            R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = isOri ? ALU_OR : ALU_ADDI;
                ZeroExt = isOri;
            end
            I_WB: begin
                RegWrite = 1'b1;
                ZeroExt  = isOri;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSource = 2'b01;
                PCEn     = ((Op == 6'h04) & Zero) | ((Op == 6'h05) & ~Zero);
            end
            JUMP: begin
                PCSource = 2'b10;
                PCEn     = 1'b1;
            end
            JR: begin
                PCSource = 2'b11;
                PCEn     = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons any in-flight instruction: no architectural write may escape.
        if (reset) begin
            PCEn     = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction expected cycle sequences
// are queued by the driver and compared against both DUT widths every cycle.
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEM_ADDR = 2, P_MEM_READ = 3, P_MEM_WB = 4;
    localparam int P_MEM_WRITE = 5, P_R_EXEC = 6, P_R_WB = 7, P_I_EXEC = 8, P_I_WB = 9;
    localparam int P_BRANCH = 10, P_JUMP = 11, P_JR = 12, P_TRAP = 13;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = '0, Funct = '0;
    logic       Zero = 1'b0, MemReady = 1'b0;

    logic        PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic        ZeroExt, ALUSrcA, IllegalOp;
    logic [1:0]  ALUSrcB, PCSource;
    logic [3:0]  ALUOp, StateOut;
    logic [31:0] RetiredCount;

    logic [10:0] misc4;
    logic [1:0]  srcB4, pcSrc4;
    logic [3:0]  aluOp4, state4, count4;

    int errors = 0;
    int checks = 0;

    logic [31:0] cntM = '0;
    logic        illM = 1'b0;
    logic [62:0] exp_q[$];
    logic [62:0] expV, actV;

    multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ZeroExt(ZeroExt),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .IllegalOp(IllegalOp), .StateOut(StateOut), .RetiredCount(RetiredCount)
    );

    multicycle_control #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .PCEn(misc4[0]), .IorD(misc4[1]), .MemRead(misc4[2]), .MemWrite(misc4[3]),
        .IRWrite(misc4[4]), .RegDst(misc4[5]), .MemtoReg(misc4[6]), .RegWrite(misc4[7]),
        .ZeroExt(misc4[8]), .ALUSrcA(misc4[9]), .ALUSrcB(srcB4), .ALUOp(aluOp4),
        .PCSource(pcSrc4), .IllegalOp(misc4[10]), .StateOut(state4), .RetiredCount(count4)
    );

    always #5 clk = ~clk;

    // Expected control word for one cycle spent in phase ph, straight from the state action table.
    function automatic logic [22:0] spec_out(int ph, logic [5:0] op, logic mr, logic z, logic ill);
        logic pcEn, iorD, memRead, memWrite, irWrite, regDst, memtoReg, regWrite, zeroExt, srcA;
        logic [1:0] srcB, pcSrc;
        logic [3:0] aluOp;
        logic isOri;
        {pcEn, iorD, memRead, memWrite, irWrite, regDst, memtoReg, regWrite, zeroExt, srcA} = '0;
        srcB = 2'b00; pcSrc = 2'b00; aluOp = 4'b0000;
        isOri = (op == 6'h0D);
        case (ph)
            P_FETCH:     begin memRead = 1; srcB = 2'b01; pcEn = mr; irWrite = mr; end
            P_DECODE:    srcB = 2'b11;
            P_MEM_ADDR:  begin srcA = 1; srcB = 2'b10; end
            P_MEM_READ:  begin iorD = 1; memRead = 1; end
            P_MEM_WB:    begin memtoReg = 1; regWrite = 1; end
            P_MEM_WRITE: begin iorD = 1; memWrite = 1; end
            P_R_EXEC:    begin srcA = 1; aluOp = 4'b0111; end
            P_R_WB:      begin regDst = 1; regWrite = 1; end
            P_I_EXEC:    begin srcA = 1; srcB = 2'b10; aluOp = isOri ? 4'b0010 : 4'b0011; zeroExt = isOri; end
            P_I_WB:      begin regWrite = 1; zeroExt = isOri; end
            P_BRANCH:    begin srcA = 1; aluOp = 4'b0001; pcSrc = 2'b01;
                               pcEn = (op == 6'h04 && z) || (op == 6'h05 && !z); end
            P_JUMP:      begin pcSrc = 2'b10; pcEn = 1; end
            P_JR:        begin pcSrc = 2'b11; pcEn = 1; end
            default: ;
        endcase
        return {4'(ph), pcEn, iorD, memRead, memWrite, irWrite, regDst, memtoReg, regWrite,
                zeroExt, srcA, srcB, aluOp, pcSrc, ill};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            expV = exp_q.pop_front();
            actV = {StateOut, PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                    ZeroExt, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, RetiredCount, count4, state4};
            checks++;
            if (actV !== expV) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t: got %h expected %h", $time, actV, expV);
            end
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(int ph, logic [5:0] op, logic mr, logic z, logic inReset);
        logic [22:0] c;
        c = spec_out(ph, op, mr, z, illM);
        if (inReset) c[16] = 1'b0;
        exp_q.push_back({c, cntM, cntM[3:0], 4'(ph)});
    endtask

    task automatic cycle(int ph, logic [5:0] op, logic [5:0] fn, logic mr, logic z);
        @(posedge clk);
        #1;
        reset = 1'b0; Op = op; Funct = fn; MemReady = mr; Zero = z;
        if (ph == P_TRAP) illM = 1'b1;
        push_exp(ph, op, mr, z, 1'b0);
    endtask

    task automatic reset_cycles(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b1; Op = 6'($urandom); Funct = 6'($urandom);
            MemReady = 1'($urandom); Zero = 1'($urandom);
            cntM = '0; illM = 1'b0;
            push_exp(P_FETCH, Op, 1'b0, Zero, 1'b1);
        end
    endtask

    task automatic idle_fetch();
        cycle(P_FETCH, 6'($urandom), 6'($urandom), 1'b0, 1'($urandom));
    endtask

    function automatic bit is_legal(logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B};
    endfunction

    // Expands one instruction into its expected phase sequence and drives it.
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, int stallF, int stallM, int abortAfter);
        int   phs[$];
        logic mrs[$];
        bit   retire;
        retire = 1'b1;
        for (int i = 0; i <= stallF; i++) begin phs.push_back(P_FETCH); mrs.push_back(i == stallF); end
        phs.push_back(P_DECODE); mrs.push_back(1'($urandom));
        if (op == 6'h23 || op == 6'h2B) begin
            phs.push_back(P_MEM_ADDR); mrs.push_back(1'($urandom));
            for (int i = 0; i <= stallM; i++) begin
                phs.push_back(op == 6'h23 ? P_MEM_READ : P_MEM_WRITE); mrs.push_back(i == stallM);
            end
            if (op == 6'h23) begin phs.push_back(P_MEM_WB); mrs.push_back(1'($urandom)); end
        end else if (op == 6'h00) begin
            if (fn == 6'h08) begin phs.push_back(P_JR); mrs.push_back(1'($urandom)); end
            else begin
                phs.push_back(P_R_EXEC); mrs.push_back(1'($urandom));
                phs.push_back(P_R_WB); mrs.push_back(1'($urandom));
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            phs.push_back(P_BRANCH); mrs.push_back(1'($urandom));
        end else if (op == 6'h02) begin
            phs.push_back(P_JUMP); mrs.push_back(1'($urandom));
        end else if (op == 6'h08 || op == 6'h0D) begin
            phs.push_back(P_I_EXEC); mrs.push_back(1'($urandom));
            phs.push_back(P_I_WB); mrs.push_back(1'($urandom));
        end else begin
            retire = 1'b0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 4; i++) begin phs.push_back(P_TRAP); mrs.push_back(1'($urandom)); end
`endif
        end
        for (int k = 0; k < phs.size(); k++) begin
            if (abortAfter > 0 && k >= abortAfter) begin retire = 1'b0; break; end
            if (phs[k] == P_FETCH) cycle(P_FETCH, 6'($urandom), 6'($urandom), mrs[k], 1'($urandom));
            else cycle(phs[k], op, fn, mrs[k], 1'($urandom));
        end
        if (retire) cntM = cntM + 32'd1;
    endtask

    task automatic branch_zero1(logic [5:0] op, logic expPcEn, string name);
        cycle(P_FETCH, 6'($urandom), 6'($urandom), 1'b1, 1'($urandom));
        cycle(P_DECODE, op, 6'($urandom), 1'($urandom), 1'($urandom));
        cycle(P_BRANCH, op, 6'($urandom), 1'($urandom), 1'b1);
        #2;
        chk({name, "_pcen"}, PCEn, expPcEn);
        chk({name, "_pcsrc"}, PCSource, 2'b01);
        cntM = cntM + 32'd1;
    endtask

    initial begin
        logic [5:0] op, fn;
        reset_cycles(3);
        #2;
        chk("reset_state", StateOut, 4'd0);
        chk("reset_count", RetiredCount, 32'd0);
        chk("reset_memread", MemRead, 1'b0);

        run_instr(6'h00, 6'h20, 0, 0, 0);
        idle_fetch(); #2;
        chk("add_count", RetiredCount, 32'd1);

        run_instr(6'h00, 6'h22, 0, 0, 3);
        reset_cycles(2);
        idle_fetch(); #2;
        chk("abort_state", StateOut, 4'd0);
        chk("abort_count", RetiredCount, 32'd0);

        run_instr(6'h23, 6'h00, 1, 3, 0);
        run_instr(6'h2B, 6'h00, 2, 2, 0);
        run_instr(6'h0D, 6'h00, 0, 0, 0);
        branch_zero1(6'h04, 1'b1, "beq");
        branch_zero1(6'h05, 1'b0, "bne");
        idle_fetch(); #2;
        chk("directed_count", RetiredCount, 32'd5);

        reset_cycles(1);
        run_instr(6'h3F, 6'h00, 0, 0, 0);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        #2;
        chk("trap_state", StateOut, 4'd13);
        chk("trap_flag", IllegalOp, 1'b1);
        reset_cycles(1);
        idle_fetch(); #2;
        chk("trap_cleared", IllegalOp, 1'b0);
`else
        idle_fetch(); #2;
        chk("nop_state", StateOut, 4'd0);
        chk("nop_count", RetiredCount, 32'd0);
`endif

        reset_cycles(1);
        for (int i = 0; i < 16; i++) begin
            run_instr(6'h08, 6'h00, 0, 0, 0);
            if (i == 14) begin
                idle_fetch(); #2;
                chk("wrap_pre", count4, 4'd15);
            end
        end
        idle_fetch(); #2;
        chk("wrap_zero", count4, 4'd0);
        chk("wrap_wide", RetiredCount, 32'd16);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2B; 3: op = 6'h04; 4: op = 6'h05;
                5: op = 6'h02; 6: op = 6'h08; 7: op = 6'h0D; 8: op = 6'h00;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            fn = ($urandom_range(0, 4) == 0) ? 6'h08 : 6'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 2));
                reset_cycles($urandom_range(1, 2));
            end else begin
                run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 0);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                if (!is_legal(op)) reset_cycles(1);
`endif
            end
        end

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
